display_scan_ctrl: RTL and testbench

//   Time-multiplexes one shared 5-input 7-segment decoder across NUM_DIGITS digits.

---
 rtl/display_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
`timescale 1ns/1ps
// Scans NUM_DIGITS shadow/active code buffers onto one shared 7-segment decoder.
// Build option: define DISPLAY_BLINK_EN to add blink_mask_i and frame-based blinking.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 32,
    localparam int AW = $clog2(NUM_DIGITS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scan_en_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [4:0]            wr_code_i,
    input  logic                  wr_commit_i,
`ifdef DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask_i,
`endif
    output logic                  wr_ready_o,
    output logic                  commit_done_o,
    output logic [4:0]            code_out_o,
    output logic [NUM_DIGITS-1:0] digit_sel_o,
    output logic                  blank_o,
    output logic                  frame_tick_o
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL0 = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    tick_d;
    logic [4:0]              shadow_q [NUM_DIGITS];
    logic [4:0]              active_q [NUM_DIGITS];
    logic                    pending_q, wrReady_q, commitDone_q, frameTick_q, blank_q;
    logic [4:0]              codeOut_q, code_d;
    logic [NUM_DIGITS-1:0]   digitSel_q;
    logic                    copyNow, wrAccept, commitAccept, dark_d, show_d;

    // The slot counter runs across the whole slot: blank phase first, then the lit phase.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (!scan_en_i) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BLANK_CYC - 1)) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == CW'(PRESCALE - 1)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A pending copy waits for a frame boundary so a half-written frame never shows.
    assign copyNow      = pending_q & (frameTick_q | (state_q == IDLE));
    assign wrAccept     = wr_en_i & wrReady_q & ({1'b0, wr_addr_i} < (AW + 1)'(NUM_DIGITS));
    assign commitAccept = wr_commit_i & wrReady_q;

`ifdef DISPLAY_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frameCnt_q, frameCnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        frameCnt_d = frameCnt_q;
        phase_d    = phase_q;
        if (state_d == IDLE) begin
            frameCnt_d = '0;
            phase_d    = 1'b0;
        end else if (tick_d) begin
            if (frameCnt_q == FW'(BLINK_FRAMES - 1)) begin
                frameCnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                frameCnt_d = frameCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frameCnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            frameCnt_q <= frameCnt_d;
            phase_q    <= phase_d;
        end
    end

    assign dark_d = phase_d & blink_mask_i[idx_d];
`else
    assign dark_d = 1'b0;
`endif

    assign show_d = (state_d == SHOW) & ~dark_d;

    // Outputs are registered from next-state values so they line up with the FSM state.
    always_comb begin
        code_d = '0;
        if (state_d != IDLE) code_d = copyNow ? shadow_q[idx_d] : active_q[idx_d];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            wrReady_q    <= 1'b1;
            commitDone_q <= 1'b0;
            frameTick_q  <= 1'b0;
            blank_q      <= 1'b1;
            codeOut_q    <= '0;
            digitSel_q   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            commitDone_q <= copyNow;
            frameTick_q  <= tick_d;
            blank_q      <= ~show_d;
            codeOut_q    <= code_d;
            digitSel_q   <= show_d ? (SEL0 << idx_d) : '0;
            if (wrAccept) shadow_q[wr_addr_i] <= wr_code_i;
            if (copyNow) begin
                for (int i = 0; i < NUM_DIGITS; i++) active_q[i] <= shadow_q[i];
                pending_q <= 1'b0;
                wrReady_q <= 1'b1;
            end else if (commitAccept) begin
                pending_q <= 1'b1;
                wrReady_q <= 1'b0;
            end
        end
    end

    assign wr_ready_o    = wrReady_q;
    assign commit_done_o = commitDone_q;
    assign code_out_o    = codeOut_q;
    assign digit_sel_o   = digitSel_q;
    assign blank_o       = blank_q;
    assign frame_tick_o  = frameTick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for display_scan_ctrl: a time-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_display_scan_ctrl;
    localparam int N = 4;
    localparam int P = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FRAME = N * P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, scanEn, wrEn, wrCommit;
    logic [1:0] wrAddr;
    logic [4:0] wrCode;
    logic       wrReady, commitDone, blank, frameTick;
    logic [4:0] codeOut;
    logic [3:0] digitSel;
`ifdef DISPLAY_BLINK_EN
    logic [3:0] blinkMask = 4'b0100;
`endif

    display_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk_i(clk), .rst_i(rst), .scan_en_i(scanEn), .wr_en_i(wrEn),
        .wr_addr_i(wrAddr), .wr_code_i(wrCode), .wr_commit_i(wrCommit),
`ifdef DISPLAY_BLINK_EN
        .blink_mask_i(blinkMask),
`endif
        .wr_ready_o(wrReady), .commit_done_o(commitDone), .code_out_o(codeOut),
        .digit_sel_o(digitSel), .blank_o(blank), .frame_tick_o(frameTick)
    );

    int checkCount = 0;
    int failCount  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the scan position is just elapsed cycles since scanning began.
    bit         modelValid = 1'b0;
    bit         mScan, mPending, mDone;
    int         mT;
    logic [4:0] mShadow [N];
    logic [4:0] mActive [N];
    bit         readyPre, prevTick, doCopy;

    always @(posedge clk) begin
        if (rst) begin
            mScan = 0; mPending = 0; mDone = 0; mT = 0;
            for (int i = 0; i < N; i++) begin
                mShadow[i] = '0;
                mActive[i] = '0;
            end
            modelValid = 1'b1;
        end else if (modelValid) begin
            readyPre = !mPending;
            prevTick = mScan && mT > 0 && (mT % FRAME == 0);
            doCopy   = mPending && (prevTick || !mScan);
            mDone    = doCopy;
            if (wrEn && readyPre && wrAddr < N) mShadow[wrAddr] = wrCode;
            if (doCopy) begin
                for (int i = 0; i < N; i++) mActive[i] = mShadow[i];
                mPending = 0;
            end else if (wrCommit && readyPre) begin
                mPending = 1;
            end
            if (!scanEn) begin
                mScan = 0; mT = 0;
            end else if (!mScan) begin
                mScan = 1; mT = 0;
            end else begin
                mT++;
            end
        end
    end

    int         eIdx;
    bit         eShow, eTick;
    logic [3:0] eSel;
    logic [4:0] eCode;

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            eSel = '0; eShow = 0; eCode = '0; eTick = 0;
            if (mScan) begin
                eIdx  = (mT / P) % N;
                eShow = (mT % P) >= BC;
`ifdef DISPLAY_BLINK_EN
                if (((mT / FRAME) / BF) % 2 == 1 && blinkMask[eIdx]) eShow = 0;
`endif
                eSel  = eShow ? 4'(1 << eIdx) : 4'b0;
                eCode = mActive[eIdx];
                eTick = mT > 0 && (mT % FRAME == 0);
            end
            checkOutput("digit_sel", 32'(digitSel), 32'(eSel));
            checkOutput("blank", 32'(blank), 32'(!eShow));
            checkOutput("code_out", 32'(codeOut), 32'(eCode));
            checkOutput("frame_tick", 32'(frameTick), 32'(eTick));
            checkOutput("wr_ready", 32'(wrReady), 32'(!mPending));
            checkOutput("commit_done", 32'(commitDone), 32'(mDone));
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] addr, input logic [4:0] code,
                                 input logic commit);
        wrEn = en; wrAddr = addr; wrCode = code; wrCommit = commit;
        waitEdges(1);
        wrEn = 1'b0; wrCommit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; scanEn = 1'b0; wrEn = 1'b0; wrCommit = 1'b0; wrAddr = '0; wrCode = '0;
        waitEdges(2);
        checkOutput("rstSel", 32'(digitSel), 32'h0);
        checkOutput("rstBlank", 32'(blank), 32'h1);
        checkOutput("rstCode", 32'(codeOut), 32'h0);
        checkOutput("rstReady", 32'(wrReady), 32'h1);
        checkOutput("rstDone", 32'(commitDone), 32'h0);
        rst = 1'b0; scanEn = 1'b1;

        waitEdges(1);
        checkOutput("firstBlank", 32'(blank), 32'h1);
        waitEdges(2);
        checkOutput("digit0Lit", 32'(digitSel), 32'h1);
        waitEdges(6);
        checkOutput("slot1Blank", 32'(digitSel), 32'h0);
        waitEdges(2);
        checkOutput("digit1Lit", 32'(digitSel), 32'h2);
        waitEdges(22);
        checkOutput("frameTickAt32", 32'(frameTick), 32'h1);

        applyStimulus(1'b1, 2'd0, 5'h01, 1'b0);
        applyStimulus(1'b1, 2'd1, 5'h02, 1'b0);
        applyStimulus(1'b1, 2'd2, 5'h03, 1'b0);
        applyStimulus(1'b1, 2'd3, 5'h04, 1'b0);
        applyStimulus(1'b0, 2'd0, 5'h00, 1'b1);
        checkOutput("readyLowAfterCommit", 32'(wrReady), 32'h0);
        applyStimulus(1'b1, 2'd0, 5'h1F, 1'b0);
        checkOutput("codeHeldBeforeTick", 32'(codeOut), 32'h0);
        for (int i = 0; i < 100 && !frameTick; i++) waitEdges(1);
        checkOutput("tickBeforeCopy", 32'(frameTick), 32'h1);
        checkOutput("noDoneOnTick", 32'(commitDone), 32'h0);
        waitEdges(1);
        checkOutput("doneAfterTick", 32'(commitDone), 32'h1);
        checkOutput("readyAfterDone", 32'(wrReady), 32'h1);
        checkOutput("newCode0", 32'(codeOut), 32'h01);
        waitEdges(8);
        checkOutput("newCode1", 32'(codeOut), 32'h02);
        waitEdges(8);
        checkOutput("newCode2", 32'(codeOut), 32'h03);
        waitEdges(8);
        checkOutput("newCode3", 32'(codeOut), 32'h04);

        scanEn = 1'b0;
        waitEdges(2);
        applyStimulus(1'b1, 2'd2, 5'h15, 1'b1);
        checkOutput("idlePending", 32'(wrReady), 32'h0);
        waitEdges(1);
        checkOutput("idleDone", 32'(commitDone), 32'h1);
        scanEn = 1'b1;
        waitEdges(19);
        checkOutput("digit2Lit", 32'(digitSel), 32'h4);
        checkOutput("digit2Code", 32'(codeOut), 32'h15);

        scanEn = 1'b0;
        waitEdges(1);
        checkOutput("dropSel", 32'(digitSel), 32'h0);
        checkOutput("dropBlank", 32'(blank), 32'h1);
        scanEn = 1'b1;
        waitEdges(3);
        checkOutput("restartDigit0", 32'(digitSel), 32'h1);

        applyStimulus(1'b0, 2'd0, 5'h00, 1'b1);
        rst = 1'b1;
        waitEdges(1);
        checkOutput("rstDropsCommit", 32'(wrReady), 32'h1);
        checkOutput("rstMidBlank", 32'(blank), 32'h1);
        rst = 1'b0;
        waitEdges(3);
        applyStimulus(1'b1, 2'd3, 5'h0A, 1'b1);
        waitEdges(220);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
